// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Receives a byte stream (length low, length high, payload bytes) and writes
//   the payload into instruction memory one byte per write, holding the core
//   in reset until a session completes successfully.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a trailing checksum byte follows the payload. The session
//     succeeds only when (sum of payload bytes + checksum byte) mod 256 == 0.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle pulse that begins a load session
//   in_valid   in   byte-stream data valid
//   in_data    in   [7:0] byte-stream payload
//   in_ready   out  loader accepts in_data this cycle
//   mem_we     out  byte write strobe (registered, one cycle after accept)
//   mem_addr   out  [ADDR_W-1:0] byte address of the write
//   mem_wdata  out  [7:0] byte to write
//   cpu_hold   out  core held in reset while high
//   load_done  out  last session completed successfully
//   load_err   out  last session ended in error
module instr_mem_loader #(
  parameter int unsigned MEM_BYTES = 88,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                accept;
  logic [15:0]         len_new;
  logic [15:0]         count_inc;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:                  in_ready = 1'b1;
`endif
      default:              in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign len_new   = {in_data, len_q[7:0]};
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          count_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = '0;
`endif
          if (32'(len_new) > MEM_BYTES) begin
            state_d = ERR;
          end else if (len_new == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          // Write is registered, so it lands on the cycle after acceptance,
          // which is also the first DONE cycle for the final byte.
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(count_q);
          mem_wdata_d = in_data;
          count_d     = count_inc;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
`endif
          if (count_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (8'(sum_q + in_data) == 8'h00) state_d = DONE;
          else                              state_d = ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = (state_q != DONE);
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter MEM_BYTES, 88, byte capacity of the instruction memory being loaded.
REQ-002 Parameter ADDR_W, 32, width of the memory byte address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 in_valid  input  1  byte-stream data valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 mem_we  output  1  byte write strobe to the instruction memory.
REQ-010 mem_addr  output  ADDR_W  byte address of the write.
REQ-011 mem_wdata  output  8  byte to write.
REQ-012 cpu_hold  output  1  holds the core in reset while high.
REQ-013 load_done  output  1  high while the last session completed successfully.
REQ-014 load_err  output  1  high while the last session ended in error.

Function
REQ-015 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE and ERR; CHK exists only per REQ-030.
REQ-016 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-017 in_ready SHALL be high exactly in LEN_LO, LEN_HI, DATA and CHK.
REQ-018 IDLE, DONE and ERR SHALL go to LEN_LO on start; start in any other state SHALL be ignored.
REQ-019 LEN_LO SHALL capture the accepted byte as len[7:0], then go to LEN_HI.
REQ-020 LEN_HI SHALL capture the accepted byte as len[15:8] and clear the byte counter.
REQ-021 From LEN_HI: len > MEM_BYTES goes to ERR, len == 0 goes to DONE (or CHK when enabled), otherwise DATA.
REQ-022 In DATA, each accepted byte SHALL produce a write exactly one cycle later: mem_we=1, mem_addr=count, mem_wdata=byte.
REQ-023 The counter SHALL increment per accepted DATA byte; the byte making count equal len SHALL exit DATA (to DONE, or CHK when enabled).
REQ-024 mem_we SHALL be high for exactly one cycle per accepted DATA byte and low otherwise.
REQ-025 Back-to-back accepted bytes SHALL sustain one write per cycle with no bubbles.
REQ-026 cpu_hold SHALL be low only in DONE; load_done SHALL be high only in DONE; load_err SHALL be high only in ERR.
REQ-027 When the final DATA write and the entry to DONE coincide, the write SHALL still issue on the first DONE cycle.

Reset
REQ-028 On reset the state SHALL be IDLE, and the outputs SHALL be in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0. The counter, length and checksum registers SHALL be cleared.
REQ-029 A reset mid-session SHALL abort the session without issuing the pending write, and SHALL take priority over start and over any handshake in the same cycle.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: the loader SHALL keep an 8-bit modulo-256 sum of the DATA bytes. CHK SHALL accept one further byte and go to DONE when sum+byte == 8'h00, else to ERR.
REQ-031 LOADER_CHECKSUM_EN undefined: there SHALL be no CHK state and no checksum logic, and DATA completion SHALL go directly to DONE.

Verification
REQ-032 Run reset, then start, then send bytes 04 00 13 05 A0 00 -> writes 13@0, 05@1, A0@2, 00@3, load_done=1, cpu_hold=0.
REQ-033 Run start, then send length 59 00 (89 > 88) -> no mem_we, load_err=1, cpu_hold=1, next start re-enters LEN_LO.
REQ-034 Run start, then send length 00 00 -> DONE with zero writes (with checksum enabled, a trailing 00 is required).
REQ-035 Send 4 data bytes with in_valid toggling every cycle -> 4 writes only on accepted bytes, addresses 0..3 in order.
REQ-036 Assert reset after 2 of 4 data bytes -> state IDLE, cpu_hold=1, no further mem_we, load_done=0.
REQ-037 LOADER_CHECKSUM_EN: data 01 02 then checksum FD -> DONE; checksum FE -> ERR.
